// File: rtl/uart_line_adapter_if.sv
// Byte-stream handshake bundle between the UART line adapter and the host byte bridge.
interface uart_line_adapter_if;
    logic       serial_out_valid;
    logic       serial_out_ready;
    logic [7:0] serial_out_bits;
    logic       serial_in_valid;
    logic       serial_in_ready;
    logic [7:0] serial_in_bits;

    modport master (
        input  serial_out_valid, serial_out_bits, serial_in_ready,
        output serial_out_ready, serial_in_valid, serial_in_bits
    );

    modport slave (
        output serial_out_valid, serial_out_bits, serial_in_ready,
        input  serial_out_ready, serial_in_valid, serial_in_bits
    );
endinterface

// File: rtl/uart_line_adapter.sv
// UART line endpoint: deserialises txd into a buffered byte stream and serialises bytes onto rxd.
// Define UART_ADAPTER_PARITY_EN for 8E1 framing in both directions; default build is 8N1.
module uart_line_adapter #(
    parameter int unsigned DIV        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               txd,
    output logic               rxd,
    uart_line_adapter_if.slave bus,
    output logic [7:0]         frame_errs,
    output logic [7:0]         overflows
);
    localparam int unsigned HALF    = DIV >> 1;
    localparam int unsigned TIMER_W = $clog2(DIV);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] T_BIT  = TIMER_W'(DIV - 1);
    localparam logic [TIMER_W-1:0] T_HALF = TIMER_W'(HALF - 1);
    // Last stop-bit cycle is spent in IDLE so back-to-back frames keep a DIV-cycle stop bit.
    localparam logic [TIMER_W-1:0] T_STOP = TIMER_W'(DIV - 2);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_ADAPTER_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_ADAPTER_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // ---------------- transmitter (serial_in -> rxd) ----------------
    tx_state_t          tx_state, tx_state_n;
    logic [TIMER_W-1:0] tx_timer, tx_timer_n;
    logic [2:0]         tx_bitcnt, tx_bitcnt_n;
    logic [7:0]         tx_shift, tx_shift_n;
    logic               rxd_n;
`ifdef UART_ADAPTER_PARITY_EN
    logic               tx_par, tx_par_n;
`endif

    assign bus.serial_in_ready = (tx_state == TX_IDLE) && !reset;

    always_comb begin
        tx_state_n  = tx_state;
        tx_timer_n  = tx_timer;
        tx_bitcnt_n = tx_bitcnt;
        tx_shift_n  = tx_shift;
        rxd_n       = rxd;
`ifdef UART_ADAPTER_PARITY_EN
        tx_par_n    = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                rxd_n = 1'b1;
                if (bus.serial_in_valid) begin
                    tx_shift_n = bus.serial_in_bits;
`ifdef UART_ADAPTER_PARITY_EN
                    tx_par_n   = ^bus.serial_in_bits;
`endif
                    tx_timer_n = T_BIT;
                    tx_state_n = TX_START;
                    rxd_n      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_timer == '0) begin
                    tx_state_n  = TX_DATA;
                    tx_timer_n  = T_BIT;
                    tx_bitcnt_n = '0;
                    rxd_n       = tx_shift[0];
                end else begin
                    tx_timer_n = tx_timer - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_timer == '0) begin
                    tx_timer_n = T_BIT;
                    if (tx_bitcnt == 3'd7) begin
`ifdef UART_ADAPTER_PARITY_EN
                        tx_state_n = TX_PARITY;
                        rxd_n      = tx_par;
`else
                        tx_state_n = TX_STOP;
                        tx_timer_n = T_STOP;
                        rxd_n      = 1'b1;
`endif
                    end else begin
                        tx_bitcnt_n = tx_bitcnt + 1'b1;
                        tx_shift_n  = {1'b0, tx_shift[7:1]};
                        rxd_n       = tx_shift[1];
                    end
                end else begin
                    tx_timer_n = tx_timer - 1'b1;
                end
            end
`ifdef UART_ADAPTER_PARITY_EN
            TX_PARITY: begin
                if (tx_timer == '0) begin
                    tx_state_n = TX_STOP;
                    tx_timer_n = T_STOP;
                    rxd_n      = 1'b1;
                end else begin
                    tx_timer_n = tx_timer - 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_timer == '0) tx_state_n = TX_IDLE;
                else                tx_timer_n = tx_timer - 1'b1;
            end
            default: begin
                tx_state_n = TX_IDLE;
                rxd_n      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_timer  <= '0;
            tx_bitcnt <= '0;
            tx_shift  <= '0;
            rxd       <= 1'b1;
`ifdef UART_ADAPTER_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_state  <= tx_state_n;
            tx_timer  <= tx_timer_n;
            tx_bitcnt <= tx_bitcnt_n;
            tx_shift  <= tx_shift_n;
            rxd       <= rxd_n;
`ifdef UART_ADAPTER_PARITY_EN
            tx_par    <= tx_par_n;
`endif
        end
    end

    // ---------------- receiver (txd -> FIFO) ----------------
    logic               sync1, sync2, rx_prev;
    rx_state_t          rx_state, rx_state_n;
    logic [TIMER_W-1:0] rx_timer, rx_timer_n;
    logic [2:0]         rx_bitcnt, rx_bitcnt_n;
    logic [7:0]         rx_shift, rx_shift_n;
    logic               push_c, frame_err_c;
`ifdef UART_ADAPTER_PARITY_EN
    logic               rx_par_err, rx_par_err_n;
`endif

    always_comb begin
        rx_state_n  = rx_state;
        rx_timer_n  = rx_timer;
        rx_bitcnt_n = rx_bitcnt;
        rx_shift_n  = rx_shift;
        push_c      = 1'b0;
        frame_err_c = 1'b0;
`ifdef UART_ADAPTER_PARITY_EN
        rx_par_err_n = rx_par_err;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !sync2) begin
                    rx_state_n = RX_START;
                    rx_timer_n = T_HALF;
                end
            end
            RX_START: begin
                if (rx_timer == '0) begin
                    rx_state_n  = sync2 ? RX_IDLE : RX_DATA;
                    rx_timer_n  = T_BIT;
                    rx_bitcnt_n = '0;
                end else begin
                    rx_timer_n = rx_timer - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_timer == '0) begin
                    rx_shift_n = {sync2, rx_shift[7:1]};
                    rx_timer_n = T_BIT;
                    if (rx_bitcnt == 3'd7) begin
`ifdef UART_ADAPTER_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_bitcnt_n = rx_bitcnt + 1'b1;
                    end
                end else begin
                    rx_timer_n = rx_timer - 1'b1;
                end
            end
`ifdef UART_ADAPTER_PARITY_EN
            RX_PARITY: begin
                if (rx_timer == '0) begin
                    rx_par_err_n = sync2 != ^rx_shift;
                    rx_state_n   = RX_STOP;
                    rx_timer_n   = T_BIT;
                end else begin
                    rx_timer_n = rx_timer - 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_timer == '0) begin
                    rx_state_n = RX_IDLE;
`ifdef UART_ADAPTER_PARITY_EN
                    if (sync2 && !rx_par_err) push_c = 1'b1;
`else
                    if (sync2) push_c = 1'b1;
`endif
                    else frame_err_c = 1'b1;
                end else begin
                    rx_timer_n = rx_timer - 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_timer  <= '0;
            rx_bitcnt <= '0;
            rx_shift  <= '0;
`ifdef UART_ADAPTER_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            sync1     <= txd;
            sync2     <= sync1;
            rx_prev   <= sync2;
            rx_state  <= rx_state_n;
            rx_timer  <= rx_timer_n;
            rx_bitcnt <= rx_bitcnt_n;
            rx_shift  <= rx_shift_n;
`ifdef UART_ADAPTER_PARITY_EN
            rx_par_err <= rx_par_err_n;
`endif
        end
    end

    // ---------------- RX byte FIFO and error counters ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_c, full_c, wr_en_c;

    assign pop_c   = bus.serial_out_valid && bus.serial_out_ready;
    assign full_c  = count == FULL_CNT;
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign bus.serial_out_valid = count != '0;
    assign bus.serial_out_bits  = (count != '0) ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clock) begin
        if (wr_en_c) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_errs <= '0;
            overflows  <= '0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + 1'b1;
            if (pop_c)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en_c && !pop_c)      count <= count + 1'b1;
            else if (!wr_en_c && pop_c) count <= count - 1'b1;
            if (frame_err_c && frame_errs != 8'hFF) frame_errs <= frame_errs + 8'd1;
            if (push_c && full_c && !pop_c && overflows != 8'hFF) overflows <= overflows + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_line_adapter.sv
// Self-checking bench for uart_line_adapter: vector table, hand-written corner cases and random traffic.
module tb_uart_line_adapter;
    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_ADAPTER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset, txd, rxd;
    logic [7:0] frame_errs, overflows;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ferr_model = 0;
    bit         mon_en   = 1'b0;
    bit         rand_rdy = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_line_adapter_if bus();

    uart_line_adapter #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .txd        (txd),
        .rxd        (rxd),
        .bus        (bus),
        .frame_errs (frame_errs),
        .overflows  (overflows)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Popped bytes: a pop happens at the next posedge whenever valid&&ready holds mid-cycle.
    initial forever begin
        @(negedge clock);
        if (mon_en && bus.serial_out_valid && bus.serial_out_ready) got.push_back(bus.serial_out_bits);
    end

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        logic       exp_valid;
        logic [7:0] exp_bits;
        logic [7:0] exp_ferr;
    } rx_vec_t;

    rx_vec_t    rx_vecs[6];
    logic [7:0] tx_vecs[4];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rand_rdy) bus.serial_out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line level of UART bit slot idx: start, 8 data LSB first, [even parity], stop.
    function automatic logic line_bit(input logic [7:0] b, input int idx, input bit stop_ok, input bit par_flip);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_ADAPTER_PARITY_EN
        if (idx == 9) return (^b) ^ par_flip;
`endif
        return stop_ok;
    endfunction

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        for (int i = 0; i < NBITS; i++) begin
            txd = line_bit(b, i, stop_ok, par_flip);
            tick(DIV);
        end
        txd = 1'b1;
    endtask

    // Caller holds serial_in_valid=1 with byte b while the transmitter is idle.
    task automatic tx_send(input logic [7:0] b, input bit chain, input logic [7:0] nb, input string name);
        int bad = 0;
        int rdy_bad = 0;
        tick();
        for (int k = 0; k < NBITS*int'(DIV); k++) begin
            if (rxd !== line_bit(b, k / int'(DIV), 1'b1, 1'b0)) bad++;
            if (bus.serial_in_ready !== (k == NBITS*int'(DIV) - 1)) rdy_bad++;
            if (k == 0) bus.serial_in_valid = 1'b0;
            if (k == NBITS*int'(DIV) - 1) begin
                if (chain) begin
                    bus.serial_in_valid = 1'b1;
                    bus.serial_in_bits  = nb;
                end
            end else begin
                tick();
            end
        end
        check({name, " rxd waveform errors"}, bad, 0);
        check({name, " ready pattern errors"}, rdy_bad, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        logic [7:0] rb[8];

        rx_vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 8'd0};
        rx_vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h00, 8'd1};
        rx_vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 8'd1};
        rx_vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'd1};
        rx_vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h00, 8'd2};
        rx_vecs[5] = '{8'h96, 1'b1, 1'b1, 8'h96, 8'd2};
        tx_vecs    = '{8'hA5, 8'h00, 8'hFF, 8'h81};

        reset = 1'b1;
        txd   = 1'b1;
        bus.serial_in_valid  = 1'b0;
        bus.serial_in_bits   = 8'h00;
        bus.serial_out_ready = 1'b0;

        // Reset state
        tick(3);
        check("reset rxd", rxd, 1);
        check("reset out_valid", bus.serial_out_valid, 0);
        check("reset out_bits", bus.serial_out_bits, 0);
        check("reset in_ready", bus.serial_in_ready, 0);
        check("reset frame_errs", frame_errs, 0);
        check("reset overflows", overflows, 0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", bus.serial_in_ready, 1);

        // TX table: A5 then 00 back-to-back, then FF and 81 back-to-back
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                bus.serial_in_valid = 1'b1;
                bus.serial_in_bits  = tx_vecs[i];
            end
            tx_send(tx_vecs[i], (i % 2 == 0), (i < 3) ? tx_vecs[i+1] : 8'h00, $sformatf("tx%0d", i));
            if (i % 2 == 1) tick(3);
        end

        // RX table with consumer stalled, then a one-cycle pop
        for (int i = 0; i < 6; i++) begin
            drive_frame(rx_vecs[i].data, rx_vecs[i].stop_ok, 1'b0);
            if (!rx_vecs[i].stop_ok) ferr_model++;
            tick(DIV + 2);
            check($sformatf("rx%0d valid", i), bus.serial_out_valid, rx_vecs[i].exp_valid);
            check($sformatf("rx%0d bits", i), bus.serial_out_bits, rx_vecs[i].exp_bits);
            check($sformatf("rx%0d frame_errs", i), frame_errs, rx_vecs[i].exp_ferr);
            tick(5);
            check($sformatf("rx%0d bits held", i), bus.serial_out_bits, rx_vecs[i].exp_bits);
            bus.serial_out_ready = 1'b1;
            tick();
            bus.serial_out_ready = 1'b0;
            check($sformatf("rx%0d valid after pop", i), bus.serial_out_valid, 0);
            check($sformatf("rx%0d bits after pop", i), bus.serial_out_bits, 0);
        end

        // One-cycle glitch on txd is ignored
        txd = 1'b0;
        tick();
        txd = 1'b1;
        tick(12);
        check("glitch valid", bus.serial_out_valid, 0);
        check("glitch frame_errs", frame_errs, 8'(ferr_model));

        // Five back-to-back frames into a 4-deep FIFO with consumer stalled
        for (int i = 1; i <= 5; i++) drive_frame(8'(i), 1'b1, 1'b0);
        tick(DIV + 2);
        check("ovf overflows", overflows, 1);
        check("ovf head", bus.serial_out_bits, 8'h01);
        got.delete();
        mon_en = 1'b1;
        bus.serial_out_ready = 1'b1;
        tick(10);
        bus.serial_out_ready = 1'b0;
        mon_en = 1'b0;
        check("ovf drained count", got.size(), DEPTH);
        for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("ovf byte%0d", i), got[i], 8'(i + 1));

        // Random TX burst, all back-to-back
        for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
        bus.serial_in_valid = 1'b1;
        bus.serial_in_bits  = rb[0];
        for (int i = 0; i < 8; i++) tx_send(rb[i], (i < 7), (i < 7) ? rb[(i + 1) % 8] : 8'h00, $sformatf("rtx%0d", i));

        // Random RX traffic with random backpressure
        got.delete();
        exp_q.delete();
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            drive_frame(b, ok, 1'b0);
            if (ok) exp_q.push_back(b);
            else    ferr_model++;
            tick(ok ? $urandom_range(0, 3) : $urandom_range(2, 5));
        end
        tick(DIV + 2);
        rand_rdy = 1'b0;
        bus.serial_out_ready = 1'b1;
        tick(8);
        bus.serial_out_ready = 1'b0;
        mon_en = 1'b0;
        check("rand rx count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) check($sformatf("rand rx byte%0d", i), got[i], exp_q[i]);
        check("rand frame_errs", frame_errs, 8'(ferr_model));
        check("rand overflows", overflows, 1);

`ifdef UART_ADAPTER_PARITY_EN
        // Bad parity drops the frame; good parity delivers it
        drive_frame(8'h07, 1'b1, 1'b1);
        ferr_model++;
        tick(DIV + 2);
        check("parity bad valid", bus.serial_out_valid, 0);
        check("parity bad frame_errs", frame_errs, 8'(ferr_model));
        drive_frame(8'h07, 1'b1, 1'b0);
        tick(DIV + 2);
        check("parity good valid", bus.serial_out_valid, 1);
        check("parity good bits", bus.serial_out_bits, 8'h07);
        bus.serial_out_ready = 1'b1;
        tick();
        bus.serial_out_ready = 1'b0;
`endif

        // Saturation of frame_errs
        for (int i = 0; i < 300; i++) begin
            drive_frame(8'hA5, 1'b0, 1'b0);
            tick(2);
        end
        tick(DIV + 2);
        check("frame_errs saturate", frame_errs, 8'hFF);
        check("no byte from bad frames", bus.serial_out_valid, 0);

        // Reset during TX data bit 3
        bus.serial_in_valid = 1'b1;
        bus.serial_in_bits  = 8'hA5;
        tick();
        bus.serial_in_valid = 1'b0;
        tick(DIV + 3*DIV + 1);
        check("mid-tx bit3", rxd, 0);
        reset = 1'b1;
        tick();
        check("mid-tx reset rxd", rxd, 1);
        check("mid-tx reset in_ready", bus.serial_in_ready, 0);
        check("mid-tx reset frame_errs", frame_errs, 0);
        check("mid-tx reset overflows", overflows, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid-tx in_ready after release", bus.serial_in_ready, 1);
        bus.serial_in_valid = 1'b1;
        bus.serial_in_bits  = 8'h3C;
        tx_send(8'h3C, 1'b0, 8'h00, "post-reset tx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
